// File: rtl/moving_avg3_pkg.sv
// moving_avg3_pkg: shared sample/sum types, FSM states and saturation helpers
// for the 3-tap moving-sum filter path.
package moving_avg3_pkg;
   localparam int SAMPLE_W = 8;
   localparam int SUM_W    = SAMPLE_W + 2;
   typedef logic signed [SAMPLE_W-1:0] sample_t;
   typedef logic signed [SUM_W-1:0]    sum_t;
   typedef logic signed [SUM_W:0]      diff_t;
   typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;
   localparam sample_t SAMPLE_MAX = sample_t'({1'b0, {(SAMPLE_W-1){1'b1}}});
   localparam sample_t SAMPLE_MIN = sample_t'({1'b1, {(SAMPLE_W-1){1'b0}}});
   localparam diff_t   DIFF_MAX   = diff_t'(SAMPLE_MAX);
   localparam diff_t   DIFF_MIN   = diff_t'(SAMPLE_MIN);
   function automatic logic out_of_range(input diff_t d);
      return (d > DIFF_MAX) || (d < DIFF_MIN);
   endfunction
   function automatic sample_t sat_sample(input diff_t d);
      return (d > DIFF_MAX) ? SAMPLE_MAX : (d < DIFF_MIN) ? SAMPLE_MIN : sample_t'(d);
   endfunction
endpackage

// File: rtl/moving_sum3_decoder_if.sv
// moving_sum3_decoder_if: sum-in / sample-out valid-ready bundle.
// slave  = decoder view (takes sums, produces samples)
// master = source/sink view (drives sums, consumes samples)
interface moving_sum3_decoder_if #(parameter int W = 8, parameter int SW = W + 2);
   logic signed [SW-1:0] sum_i;
   logic                 sum_valid_i;
   logic                 sum_ready_o;
   logic signed [W-1:0]  x_o;
   logic                 x_valid_o;
   logic                 x_ready_i;
   modport slave  (input sum_i, sum_valid_i, x_ready_i, output sum_ready_o, x_o, x_valid_o);
   modport master (output sum_i, sum_valid_i, x_ready_i, input sum_ready_o, x_o, x_valid_o);
endinterface

// File: rtl/moving_sum3_decoder_hist.sv
// moving_sum3_decoder_hist: history shift register (s_prev, x1..x3) for the decoder.
// i_load shifts in a new sum/sample; i_clear zeroes the history. When both are
// set the clear happens first, so only the freshly loaded pair survives.
// Ports: system1000/system1000_rst clock and sync reset, i_clear, i_load,
// i_sum/i_x new sum and reconstructed sample, o_s_prev/o_x3 taps used by the top.
module moving_sum3_decoder_hist
   import moving_avg3_pkg::*;
(
   input  logic    system1000,
   input  logic    system1000_rst,
   input  logic    i_clear,
   input  logic    i_load,
   input  sum_t    i_sum,
   input  sample_t i_x,
   output sum_t    o_s_prev,
   output sample_t o_x3
);
   sum_t    r_s_prev;
   sample_t r_x1, r_x2, r_x3;
   always_ff @(posedge system1000) begin
      if (system1000_rst || (i_clear && !i_load)) begin
         r_s_prev <= '0;
         r_x1     <= '0;
         r_x2     <= '0;
         r_x3     <= '0;
      end else if (i_load) begin
         r_s_prev <= i_sum;
         r_x1     <= i_x;
         r_x2     <= i_clear ? '0 : r_x1;
         r_x3     <= i_clear ? '0 : r_x2;
      end
   end
   assign o_s_prev = r_s_prev;
   assign o_x3     = r_x3;
endmodule

// File: rtl/moving_sum3_decoder.sv
// moving_sum3_decoder: rebuilds x[n] = s[n] - s[n-1] + x[n-3] from a 3-tap sum stream.
// Ports: system1000/system1000_rst clock and sync reset, bus (slave: sum in,
// sample out, valid/ready), clear_i history clear + fault exit, err_o sticky
// range error.
module moving_sum3_decoder
   import moving_avg3_pkg::*;
#(
   parameter int W  = SAMPLE_W,
   parameter int SW = W + 2
)
(
   input  logic                   system1000,
   input  logic                   system1000_rst,
   moving_sum3_decoder_if.slave   bus,
   input  logic                   clear_i,
   output logic                   err_o
);
   logic                 w_accept;
   logic signed [SW-1:0] w_s_prev, w_s_prev_hist;
   logic signed [W-1:0]  w_x3, w_x3_hist, w_xs;
   logic signed [SW:0]   w_d;
   logic                 w_ovf;
   logic signed [W-1:0]  r_x;
   logic                 r_x_valid;
   state_t               r_state;
   assign bus.sum_ready_o = !r_x_valid || bus.x_ready_i;
   assign w_accept        = bus.sum_valid_i && bus.sum_ready_o;
   // A coincident clear means this sample sees an all-zero history.
   assign w_s_prev = clear_i ? '0 : w_s_prev_hist;
   assign w_x3     = clear_i ? '0 : w_x3_hist;
   assign w_d      = (SW+1)'(bus.sum_i) - (SW+1)'(w_s_prev) + (SW+1)'(w_x3);
   assign w_xs     = sat_sample(w_d);
   assign w_ovf    = out_of_range(w_d);
   moving_sum3_decoder_hist u_hist (
      .system1000     (system1000),
      .system1000_rst (system1000_rst),
      .i_clear        (clear_i),
      .i_load         (w_accept),
      .i_sum          (bus.sum_i),
      .i_x            (w_xs),
      .o_s_prev       (w_s_prev_hist),
      .o_x3           (w_x3_hist)
   );
   always_ff @(posedge system1000) begin
      if (system1000_rst) begin
         r_x       <= '0;
         r_x_valid <= 1'b0;
         r_state   <= RUN;
      end else begin
         if (w_accept) begin
            r_x       <= w_xs;
            r_x_valid <= 1'b1;
         end else if (bus.x_ready_i) begin
            r_x_valid <= 1'b0;
         end
         // A new fault outranks a coincident clear.
         if (w_accept && w_ovf)
            r_state <= FAULT;
         else if (clear_i)
            r_state <= RUN;
      end
   end
   assign bus.x_o       = r_x;
   assign bus.x_valid_o = r_x_valid;
   assign err_o         = (r_state == FAULT);
endmodule

// File: tb/tb_moving_sum3_decoder.sv
// tb_moving_sum3_decoder: directed and random loopback checks of the sum decoder.
module tb_moving_sum3_decoder;
   localparam int N = 1000;
   logic system1000 = 1'b0;
   logic system1000_rst = 1'b1;
   logic clear_i = 1'b0;
   logic err_o;
   int   n_vec = 0;
   int   n_err = 0;
   int   xs[N];
   int   ss[N];
   moving_sum3_decoder_if #(.W(8), .SW(10)) bus ();
   moving_sum3_decoder dut (
      .system1000     (system1000),
      .system1000_rst (system1000_rst),
      .bus            (bus),
      .clear_i        (clear_i),
      .err_o          (err_o)
   );
   always #5 system1000 = ~system1000;
   task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic cyc();
      @(posedge system1000);
      #1;
   endtask
   task automatic do_reset();
      system1000_rst  = 1'b1;
      clear_i         = 1'b0;
      bus.sum_valid_i = 1'b0;
      bus.x_ready_i   = 1'b1;
      cyc();
      system1000_rst = 1'b0;
   endtask
   task automatic send(input int s, input int exp, input string tag);
      bus.sum_i       = 10'(s);
      bus.sum_valid_i = 1'b1;
      cyc();
      chk(tag, 32'($signed(bus.x_o)), exp);
      chk({tag, "_v"}, 32'(bus.x_valid_o), 1);
      bus.sum_valid_i = 1'b0;
   endtask
   initial begin
      int imp_s[5] = '{5, 5, 5, 0, 0};
      int imp_x[5] = '{0, 0, 0, 0, 0};
      int si, oi, cycles;
      imp_x[0] = 5;
      bus.sum_i = '0;
      bus.sum_valid_i = 1'b0;
      bus.x_ready_i = 1'b1;
      do_reset();
      #1;
      chk("rst_x", 32'($signed(bus.x_o)), 0);
      chk("rst_xv", 32'(bus.x_valid_o), 0);
      chk("rst_err", 32'(err_o), 0);
      chk("rst_rdy", 32'(bus.sum_ready_o), 1);
      // impulse
      for (int i = 0; i < 5; i++) begin
         send(imp_s[i], imp_x[i], "imp");
         chk("imp_err", 32'(err_o), 0);
      end
      cyc();
      chk("imp_drain", 32'(bus.x_valid_o), 0);
      // backpressure
      do_reset();
      send(17, 17, "bp_first");
      bus.sum_i = 10'(17);
      bus.sum_valid_i = 1'b1;
      bus.x_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("bp_rdy", 32'(bus.sum_ready_o), 0);
         cyc();
         chk("bp_hold", 32'($signed(bus.x_o)), 17);
         chk("bp_hold_v", 32'(bus.x_valid_o), 1);
      end
      bus.x_ready_i = 1'b1;
      #1;
      chk("bp_rdy_back", 32'(bus.sum_ready_o), 1);
      cyc();
      chk("bp_next", 32'($signed(bus.x_o)), 0);
      bus.sum_valid_i = 1'b0;
      // fault
      do_reset();
      send(300, 127, "flt_sat");
      chk("flt_err", 32'(err_o), 1);
      send(300, 0, "flt_next");
      chk("flt_err2", 32'(err_o), 1);
      send(10, -128, "flt_neg");
      chk("flt_err3", 32'(err_o), 1);
      clear_i = 1'b1;
      cyc();
      clear_i = 1'b0;
      chk("flt_clr", 32'(err_o), 0);
      send(3, 3, "flt_a");
      send(3, 0, "flt_b");
      chk("flt_ok", 32'(err_o), 0);
      // clear coinciding with a fault stays in fault
      clear_i = 1'b1;
      send(400, 127, "clrflt");
      clear_i = 1'b0;
      chk("clrflt_err", 32'(err_o), 1);
      // clear coinciding with accept
      do_reset();
      send(10, 10, "sim_a");
      send(30, 20, "sim_b");
      send(60, 30, "sim_c");
      clear_i = 1'b1;
      send(-7, -7, "sim_clr");
      clear_i = 1'b0;
      send(-7, 0, "sim_after");
      // mid-stream reset
      do_reset();
      send(300, 127, "mid_pre");
      bus.x_ready_i = 1'b0;
      cyc();
      chk("mid_held", 32'(bus.x_valid_o), 1);
      system1000_rst = 1'b1;
      cyc();
      system1000_rst = 1'b0;
      bus.x_ready_i = 1'b1;
      chk("mid_xv", 32'(bus.x_valid_o), 0);
      chk("mid_x", 32'($signed(bus.x_o)), 0);
      chk("mid_err", 32'(err_o), 0);
      send(2, 2, "mid_post");
      // random loopback through a reference 3-tap sum
      do_reset();
      for (int n = 0; n < N; n++) begin
         xs[n] = int'($urandom_range(255)) - 128;
         ss[n] = xs[n] + ((n > 0) ? xs[n-1] : 0) + ((n > 1) ? xs[n-2] : 0);
      end
      si = 0;
      oi = 0;
      cycles = 0;
      while (oi < N && cycles < 20000) begin
         bus.sum_valid_i = (si < N) && ($urandom_range(3) != 0);
         bus.sum_i = 10'((si < N) ? ss[si] : 0);
         bus.x_ready_i = ($urandom_range(3) != 0);
         #1;
         if (bus.x_valid_o && bus.x_ready_i) begin
            chk("loop", 32'($signed(bus.x_o)), xs[oi]);
            oi++;
         end
         if (bus.sum_valid_i && bus.sum_ready_o)
            si++;
         @(posedge system1000);
         #1;
         cycles++;
      end
      chk("loop_count", oi, N);
      chk("loop_err", 32'(err_o), 0);
      bus.sum_valid_i = 1'b0;
      bus.x_ready_i = 1'b1;
      cyc();
      chk("loop_drain", 32'(bus.x_valid_o), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/moving_sum3_decoder.md
# moving_sum3_decoder

Inverse of the 3-tap moving filter. It accepts the undivided 3-sample sum stream s[n] = x[n] + x[n-1] + x[n-2] and reconstructs the original signed 8-bit samples x[n]. The recurrence is x[n] = s[n] − s[n-1] + x[n-3], with all history zero after reset. It sits at the receive end of the filter loopback path and drives a valid/ready sink. Out-of-range reconstructions are detected and latched so the system can resynchronise.

## Interface
Parameters:
- W, 8: sample width (signed).
- SW, W+2: sum input width (signed); holds 3·(−2^(W−1)) without overflow.

Ports:
- system1000  in  1  clock; all logic on rising edge.
- system1000_rst  in  1  synchronous reset, active high.
- sum_i  in  SW  signed moving-sum sample.
- sum_valid_i  in  1  sum_i is valid.
- sum_ready_o  out  1  block accepts sum_i this cycle.
- x_o  out  W  reconstructed sample, signed.
- x_valid_o  out  1  x_o is valid.
- x_ready_i  in  1  sink accepts x_o.
- clear_i  in  1  zero the history and leave FAULT (synchronous).
- err_o  out  1  sticky reconstruction-range error.

## Operation
- Reset values:
  - x_o = 0, x_valid_o = 0, err_o = 0, state = RUN.
  - History s_prev, x1, x2, x3 all 0.
  - sum_ready_o = 1 in the first cycle after reset.
- Accept: a sum is taken when sum_valid_i && sum_ready_o.
- Ready: sum_ready_o = !x_valid_o || x_ready_i. This is combinational from the output register only, so there is no sum_valid_i → sum_ready_o path.
- On accept:
  - Compute d = sum_i − s_prev + x3 in SW+1 bits, sign-extending all operands.
  - Saturate d to [−2^(W−1), 2^(W−1)−1] to give xs.
  - Load x_o ← xs and set x_valid_o ← 1.
  - Shift history: x3 ← x2, x2 ← x1, x1 ← xs, s_prev ← sum_i.
  - Note that x1 holds x[n-1], so after the shift x3 holds x[n-2], which becomes x[n-3] for the next sample.
- Output: x_valid_o clears on x_ready_i when no new accept occurs in the same cycle. Accept and drain in the same cycle leaves x_valid_o = 1 with the new data.
- Stall: x_o and x_valid_o hold stable while x_valid_o && !x_ready_i.
- State machine:
  - RUN → FAULT when d is outside the range on an accept.
  - FAULT → RUN on clear_i.
  - In FAULT, samples are still reconstructed (saturated) and passed through.
  - err_o = (state == FAULT).
- clear_i:
  - Zeroes s_prev, x1, x2, x3 and sets state to RUN.
  - Does not touch x_o or x_valid_o; a pending output still drains.
  - If clear_i and an accept coincide, the accept uses zero history (clear first) and the result enters the cleared history.
  - If clear_i and a new fault coincide, state = FAULT.
- Reset has priority over clear_i and the handshake. Reset mid-stream drops any held x_o.

## Timing
- Latency: 1 cycle from sum accept to x_valid_o.
- Throughput: 1 sample per cycle while x_ready_i = 1.
- err_o asserts in the same cycle that the faulting x_o appears.
- clear_i takes effect at the next edge; err_o is low the cycle after.
- The combinational path is a two-adder chain plus saturation, within one cycle.

## Structure
- Shared package moving_avg3_pkg:
  - Typedefs sample_t (signed W) and sum_t (signed SW).
  - State enum {RUN, FAULT}.
  - Constant SAMPLE_MAX / SAMPLE_MIN.
  - Function sat_sample(d).
- Sub-module: moving_sum3_decoder_hist, which holds the history shift register (s_prev, x1..x3) with clear and load enables. Everything else stays in the top.

## Test plan
- Impulse: after reset, sums 5, 5, 5, 0, 0 with the sink always ready → x_o = 5, 0, 0, 0, 0, each 1 cycle after accept; err_o stays 0.
- Loopback: random x in [−128, 127] through a reference 3-tap sum, 1000 samples with random sum_valid_i / x_ready_i → bit-exact x sequence, no drops or duplicates.
- Backpressure: x_ready_i = 0 for 4 cycles with the output holding 17 → x_o stays 17 and sum_ready_o = 0. When x_ready_i returns high, the next sample is accepted that cycle.
- Fault:
  - After reset, feed sum 300 → x_o = 127, err_o = 1 the same cycle.
  - Following sums keep err_o = 1.
  - clear_i pulse → err_o = 0 next cycle. Then sums 3, 3 → x_o = 3, 0.
- Simultaneous clear and accept: history nonzero (previous x = 10, 20, 30). Assert clear_i while sum_i = −7 is accepted → x_o = −7.
- Mid-stream reset: assert system1000_rst with x_valid_o = 1 → next cycle x_valid_o = 0, x_o = 0, err_o = 0. Then sum 2 → x_o = 2.
